mat_trans_stream: RTL
=====================

// Module: mat_trans_stream
// PURPOSE
//  Streaming fixed-point matrix transpose: accepts a MATRIX_SIZE x MATRIX_SIZE matrix one element
//  per cycle in row-major order and emits its transpose one element per cycle, also row-major.
//  Successor to the combinational mattrans<n> blocks. Ping-pong double buffer sustains
//  1 element/clk with valid/ready on both sides. Sits between the matrix producers and consumers
//  in the navigation datapath.
// PARAMETERS
//  DATA_WIDTH   32  element width in bits (signed fixed point)
//  BIN_POS      16  binary point position; data passes through unmodified; must be < DATA_WIDTH
//  MATRIX_SIZE  4   N, matrix dimension; legal 1..16
// PORTS
//  clk        in   1           single clock, all logic on rising edge
//  rst_n      in   1           synchronous reset, active low
//  in_data    in   DATA_WIDTH  input element
//  in_valid   in   1           in_data valid
//  in_ready   out  1           block can accept; transfer when in_valid & in_ready
//  out_data   out  DATA_WIDTH  output element
//  out_valid  out  1           out_data valid
//  out_ready  in   1           consumer accepts; transfer when out_valid & out_ready
//  out_last   out  1           high with the final element (index N*N-1) of each output frame
//  bypass     in   1           only with MAT_TRANS_BYPASS_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset (rst_n low at an edge): out_valid=0, out_last=0, out_data=0, in_ready=0 while low;
//    both bank-full flags, write/read counters and bank selects cleared to 0. Partial frames are
//    discarded (no output). in_ready=1 the first cycle after rst_n returns high.
//  - Storage: two banks of N*N words. Write side fills bank wr_sel at index wr_idx (0..N*N-1),
//    incrementing per input handshake. On the handshake with wr_idx=N*N-1: full[wr_sel]<=1,
//    wr_sel toggles, wr_idx<=0.
//  - in_ready = rst_n_q & ~full[wr_sel] (registered state only; no combinational path from out_ready).
//  - Read side: output index j=0..N*N-1 from bank rd_sel, row r=j/N, col c=j%N;
//    out_data = bank[c*N+r] (trans[r][c]=in[c][r]). Counters use row/col registers; no divider.
//  - Output register: loads when full[rd_sel] & (~out_valid | out_ready). Holds out_data,
//    out_valid and out_last stable while out_valid & ~out_ready.
//  - On the load of j=N*N-1: out_last=1 on that element; full[rd_sel]<=0; rd_sel toggles.
//  - Latency: last input handshake at edge k -> element (0,0) valid after edge k+1.
//    Throughput 1 element/clk with out_ready held high; no bubbles between frames.
//  - Simultaneous: bank freed by read and next bank filled on the same edge are both honoured.
//    A write into a bank and the read from the other bank are independent.
//  - Full: both banks full -> in_ready=0 until the read side frees a bank. Empty: out_valid=0.
//  - N=1: every element is its own frame; out_last=1 on every output.
// CONFIGURATION
//  MAT_TRANS_BYPASS_EN defined: adds port bypass. It is sampled per bank on the write handshake
//    with wr_idx=0 and stored as a per-bank mode bit. Mode=1 frames are read in plain row-major
//    order (out_data=bank[j], identity). Latency, handshake and out_last are unchanged.
//  MAT_TRANS_BYPASS_EN undefined: no bypass port, no mode bits; every frame is transposed.
// TESTING
//  1. N=4, out_ready=1, in 0..15 back-to-back -> out 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15;
//     out_last on 15; first out_valid 1 clk after last input.
//  2. N=4, two frames 0..15 then 100..115 contiguous, out_ready=1 -> 32 consecutive outputs,
//     no gaps; in_ready never drops.
//  3. N=4, out_ready=0 -> in_ready falls after 32 accepts. Raise out_ready after 5 idle clks ->
//     first out_data=0 held stable throughout the stall; in_ready returns once frame 1 drains.
//  4. Reset after 7 of 16 inputs -> out_valid stays 0. Next full frame 0..15 transposes correctly.
//  5. N=3, DATA_WIDTH=48, BIN_POS=40, random signed values vs. golden transpose model; N=1 ->
//     out equals in, out_last on every element.
//  6. MAT_TRANS_BYPASS_EN: frame A bypass=1, frame B bypass=0 -> A in order 0..15, B transposed.

Source files
------------

// File: rtl/mat_trans_stream.sv
// -----------------------------------------------------------------------------
// mat_trans_stream
//
// Streaming fixed-point matrix transpose. A MATRIX_SIZE x MATRIX_SIZE matrix
// arrives one element per clock in row-major order and its transpose leaves
// one element per clock, also row-major. Two banks of N*N words form a
// ping-pong buffer: one bank fills while the other is read out, so a steady
// stream runs at 1 element/clk with no bubbles between frames. Element values
// are passed through untouched (BIN_POS only documents the fixed-point format).
//
// Optional feature (compile-time macro MAT_TRANS_BYPASS_EN):
//   Adds input port 'bypass'. It is sampled with the first element of each
//   frame and stored as a per-bank mode bit; a mode=1 frame is read back in
//   plain row-major order (identity) instead of transposed.
//
// Parameters
//   DATA_WIDTH   element width in bits (signed fixed point)
//   BIN_POS      binary point position, must be < DATA_WIDTH
//   MATRIX_SIZE  N, matrix dimension, 1..16
//
// Ports
//   clk        in   rising-edge clock for all logic
//   rst_n      in   synchronous reset, active low
//   in_data    in   input element
//   in_valid   in   in_data valid
//   in_ready   out  block can accept; transfer when in_valid & in_ready
//   out_data   out  output element (registered)
//   out_valid  out  out_data valid (registered)
//   out_ready  in   consumer accepts; transfer when out_valid & out_ready
//   out_last   out  high with the final element (index N*N-1) of each frame
//   bypass     in   only with MAT_TRANS_BYPASS_EN: frame passes untransposed
//
// Handshake: a word moves on every rising edge where valid and ready are both
// high; once valid is raised the producer keeps data stable until that edge,
// and ready never depends combinationally on the same side's valid.
// -----------------------------------------------------------------------------
module mat_trans_stream #(
    parameter int DATA_WIDTH  = 32,
    parameter int BIN_POS     = 16,
    parameter int MATRIX_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
`ifdef MAT_TRANS_BYPASS_EN
    ,
    input  logic                  bypass
`endif
);

    // -------------------------------------------------------------------------
    // Derived sizes. Widths are clamped to at least one bit so that N=1
    // (single-element frames) still elaborates cleanly.
    // -------------------------------------------------------------------------
    localparam int NN = MATRIX_SIZE * MATRIX_SIZE;
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam int CW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);
    localparam logic [CW-1:0] LAST_RC  = CW'(MATRIX_SIZE - 1);
    localparam logic [IW-1:0] STEP_N   = IW'(MATRIX_SIZE);
    localparam logic [IW-1:0] ONE_I    = IW'(1);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    generate
        if (BIN_POS >= DATA_WIDTH || BIN_POS < 0) begin : g_bad_bin_pos
            $error("mat_trans_stream: BIN_POS must be in 0..DATA_WIDTH-1");
        end
        if (MATRIX_SIZE < 1 || MATRIX_SIZE > 16) begin : g_bad_size
            $error("mat_trans_stream: MATRIX_SIZE must be in 1..16");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] bank_mem [0:1][0:NN-1];

    logic          rst_n_q;   // keeps in_ready low for the whole reset window
    logic [1:0]    full;      // per-bank "complete frame waiting to be read"
    logic [1:0]    full_nxt;

    logic          wr_sel;
    logic [IW-1:0] wr_idx;

    logic          rd_sel;
    logic [IW-1:0] rd_idx;    // output index j, row-major over the result
    logic [CW-1:0] rd_row;    // r = j / N
    logic [CW-1:0] rd_col;    // c = j % N
    logic [IW-1:0] rd_tidx;   // c*N + r, tracked incrementally (no multiplier)
    logic [IW-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_word;

    logic          wr_fire;
    logic          rd_load;
    logic          wr_frame_end;
    logic          rd_frame_end;

`ifdef MAT_TRANS_BYPASS_EN
    logic [1:0]    mode;      // per-bank: 1 = read back untransposed
`endif

    // -------------------------------------------------------------------------
    // Handshake qualifiers. in_ready is built only from registered state so
    // the consumer's out_ready never reaches the producer combinationally.
    // -------------------------------------------------------------------------
    assign in_ready     = rst_n_q & ~full[wr_sel];
    assign wr_fire      = in_valid & in_ready;
    assign wr_frame_end = wr_fire & (wr_idx == LAST_IDX);

    // The output register refills whenever it is empty or being drained.
    assign rd_load      = full[rd_sel] & (~out_valid | out_ready);
    assign rd_frame_end = rd_load & (rd_idx == LAST_IDX);

    // Bank flags: completing a write and finishing a read on the same edge
    // always touch different banks (one is full, the other is not), so both
    // updates are applied independently.
    always_comb begin
        full_nxt = full;
        if (wr_frame_end) begin
            full_nxt[wr_sel] = 1'b1;
        end
        if (rd_frame_end) begin
            full_nxt[rd_sel] = 1'b0;
        end
    end

    // Read address: transposed element (r,c) of the result is input (c,r),
    // stored at c*N + r. Identity frames simply use j.
    always_comb begin
        rd_addr = rd_tidx;
`ifdef MAT_TRANS_BYPASS_EN
        if (mode[rd_sel]) begin
            rd_addr = rd_idx;
        end
`endif
    end

    assign rd_word = bank_mem[rd_sel][rd_addr];

    // -------------------------------------------------------------------------
    // Storage write. The array carries no reset; stale contents are never
    // read because a bank is only read after it has been completely refilled.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_mem[wr_sel][wr_idx] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Control: write counters, read counters, output register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q   <= 1'b0;
            full      <= 2'b00;
            wr_sel    <= 1'b0;
            wr_idx    <= '0;
            rd_sel    <= 1'b0;
            rd_idx    <= '0;
            rd_row    <= '0;
            rd_col    <= '0;
            rd_tidx   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
`ifdef MAT_TRANS_BYPASS_EN
            mode      <= 2'b00;
`endif
        end else begin
            rst_n_q <= 1'b1;
            full    <= full_nxt;

            // Write side
            if (wr_fire) begin
`ifdef MAT_TRANS_BYPASS_EN
                if (wr_idx == '0) begin
                    mode[wr_sel] <= bypass;
                end
`endif
                if (wr_idx == LAST_IDX) begin
                    wr_idx <= '0;
                    wr_sel <= ~wr_sel;
                end else begin
                    wr_idx <= wr_idx + ONE_I;
                end
            end

            // Read side / output register
            if (rd_load) begin
                out_valid <= 1'b1;
                out_data  <= rd_word;
                out_last  <= (rd_idx == LAST_IDX);

                if (rd_idx == LAST_IDX) begin
                    rd_idx  <= '0;
                    rd_row  <= '0;
                    rd_col  <= '0;
                    rd_tidx <= '0;
                    rd_sel  <= ~rd_sel;
                end else begin
                    rd_idx <= rd_idx + ONE_I;
                    if (rd_col == LAST_RC) begin
                        // Next row of the result starts at input column 0,
                        // row r+1, i.e. address r+1.
                        rd_col  <= '0;
                        rd_row  <= rd_row + ONE_C;
                        rd_tidx <= IW'(rd_row) + ONE_I;
                    end else begin
                        // Next result column = next input row: skip N words.
                        rd_col  <= rd_col + ONE_C;
                        rd_tidx <= rd_tidx + STEP_N;
                    end
                end
            end else if (out_ready) begin
                // Element consumed and nothing to replace it with.
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
